// File: rtl/gf569_mul_feed.sv
// rtl/gf569_mul_feed.sv - two-stage GF(569) operand multiplier feeding the Barrett reducer
//
// Purpose: accepts operand pairs, flags out-of-range residues, multiplies them and
// presents the full-width product to the downstream reducer through a 2-deep pipeline
// with ready/valid flow control on both sides.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream offers an operand pair
//   in_ready   pair is accepted this cycle
//   in_a/in_b  operands, residues mod MOD
//   out_valid  product beat available
//   out_ready  downstream consumes the beat
//   out_prod   unsigned A*B (0 on error beats)
//   out_err    beat carried an out-of-range operand
//   err_cnt    saturating count of accepted error beats
//   beat_cnt   wrapping count of accepted beats
module gf569_mul_feed #(
  parameter int MOD    = 569,
  parameter int OP_W   = 10,
  parameter int PROD_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_prod,
  output logic              out_err,
  output logic [7:0]        err_cnt,
  output logic [15:0]       beat_cnt
);

  localparam int EXT_W = PROD_W - OP_W;
  // One extra bit so a modulus equal to 2^OP_W still compares correctly.
  localparam logic [OP_W:0] MOD_L = (OP_W + 1)'(MOD);

  logic              s1_valid;
  logic [OP_W-1:0]   s1_a;
  logic [OP_W-1:0]   s1_b;
  logic              s1_err;
  logic              s2_valid;
  logic [PROD_W-1:0] s2_prod;
  logic              s2_err;

  logic              s2_adv;
  logic              s1_adv;
  logic              in_acc;
  logic              in_err;
  logic [PROD_W-1:0] mul_res;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign in_acc   = in_valid && in_ready;
  assign in_err   = ({1'b0, in_a} >= MOD_L) || ({1'b0, in_b} >= MOD_L);

  // Operands below MOD always fit; error beats are forced to zero regardless.
  assign mul_res = {{EXT_W{1'b0}}, s1_a} * {{EXT_W{1'b0}}, s1_b};

  // Stage 1: operand capture. Data registers only load on a real acceptance so
  // undriven operands while in_valid is low never reach state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_err   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_err <= in_err;
      end
    end
  end

  // Stage 2: product register, held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod <= s1_err ? '0 : mul_res;
        s2_err  <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      err_cnt  <= '0;
    end else if (in_acc) begin
      beat_cnt <= beat_cnt + 16'd1;
      if (in_err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_prod  = s2_prod;
  assign out_err   = s2_err;

endmodule
